// File: rtl/dot_pkg.sv
// Shared widths, result-width derivation and stage-valid bundle for the dot-product datapath.
package dot_pkg;
  localparam int DATA_WIDTH        = 8;
  localparam int ADDR_WIDTH        = 4;
  localparam int NUMS_DATA_IN_BITS = 2;

  // Full-precision sum of 2^nb products of two dw-bit operands
  function automatic int acc_width(input int dw, input int nb);
    return 2 * dw + nb;
  endfunction

  typedef struct packed {
    logic s1;
    logic s2;
    logic s3;
  } stage_vld_t;
endpackage

// File: rtl/dot_product_mac.sv
// S2 multiply and S3 accumulate stages of the dot-product pipeline.
// DOT_SIGNED_EN selects two's-complement operands, products and accumulator.
module dot_product_mac import dot_pkg::*; #(
  parameter int Data_Width = DATA_WIDTH,
  parameter int Acc_Width  = acc_width(DATA_WIDTH, NUMS_DATA_IN_BITS)
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic                  in_last,
  input  logic [Data_Width-1:0] a,
  input  logic [Data_Width-1:0] b,
  output logic                  s2_vld,
  output logic                  s3_vld,
  output logic                  s3_last,
  output logic [Acc_Width-1:0]  acc
);
  localparam int PW = 2 * Data_Width;

  logic [PW-1:0]        mul, prod;
  logic [Acc_Width-1:0] prod_ext;
  logic                 s2_last;
  logic                 cont;

`ifdef DOT_SIGNED_EN
  assign mul      = PW'($signed(a)) * PW'($signed(b));
  assign prod_ext = Acc_Width'($signed(prod));
`else
  assign mul      = PW'(a) * PW'(b);
  assign prod_ext = Acc_Width'(prod);
`endif

  // cont is the inverse of the "first element" flag: clear means next element starts a sum
  always_ff @(posedge clk) begin
    if (flush) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s3_vld  <= 1'b0;
      s3_last <= 1'b0;
      cont    <= 1'b0;
      acc     <= '0;
      prod    <= '0;
    end else begin
      s2_vld  <= in_vld;
      s2_last <= in_vld & in_last;
      if (in_vld) prod <= mul;
      s3_vld  <= s2_vld;
      s3_last <= s2_vld & s2_last;
      if (s2_vld) begin
        acc  <= cont ? acc + prod_ext : prod_ext;
        cont <= !s2_last;
      end
    end
  end
endmodule

// File: rtl/dot_product_datapath.sv
// Four-stage multiply-accumulate datapath: S1 capture, S2/S3 in dot_product_mac, S4 writeback.
// Define DOT_SIGNED_EN for two's-complement arithmetic.
module dot_product_datapath import dot_pkg::*; #(
  parameter int Data_Width        = DATA_WIDTH,
  parameter int Addr_Width        = ADDR_WIDTH,
  parameter int Nums_Data_in_bits = NUMS_DATA_IN_BITS,
  parameter int Nums_Data         = 1 << Nums_Data_in_bits,
  parameter int Acc_Width         = acc_width(Data_Width, Nums_Data_in_bits)
) (
  input  logic                         clk,
  input  logic                         Comp_reset_n,
  input  logic                         Clear,
  input  logic                         In_Valid,
  input  logic [Data_Width-1:0]        Data_A,
  input  logic [Data_Width-1:0]        Data_B,
  output logic                         Out_Valid,
  output logic [Acc_Width-1:0]         Out_Data,
  output logic [Addr_Width-1:0]        Out_Addr,
  output logic                         Busy,
  output logic [Nums_Data_in_bits-1:0] Elem_Count
);
  stage_vld_t            vld;
  logic                  flush;
  logic                  s1_vld, s1_last;
  logic [Data_Width-1:0] s1_a, s1_b;
  logic                  s2_vld, s3_vld, s3_last;
  logic [Acc_Width-1:0]  acc;

  assign flush = !Comp_reset_n || Clear;
  assign vld   = '{s1: s1_vld, s2: s2_vld, s3: s3_vld};
  assign Busy  = |vld;

  always_ff @(posedge clk) begin
    if (flush) begin
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      Elem_Count <= '0;
    end else begin
      s1_vld  <= In_Valid;
      s1_last <= In_Valid && (Elem_Count == Nums_Data_in_bits'(Nums_Data - 1));
      if (In_Valid) begin
        s1_a       <= Data_A;
        s1_b       <= Data_B;
        Elem_Count <= Elem_Count + Nums_Data_in_bits'(1);
      end
    end
  end

  dot_product_mac #(
    .Data_Width (Data_Width),
    .Acc_Width  (Acc_Width)
  ) u_mac (
    .clk     (clk),
    .flush   (flush),
    .in_vld  (s1_vld),
    .in_last (s1_last),
    .a       (s1_a),
    .b       (s1_b),
    .s2_vld  (s2_vld),
    .s3_vld  (s3_vld),
    .s3_last (s3_last),
    .acc     (acc)
  );

  // Out_Addr survives Clear; it advances once per completed write
  always_ff @(posedge clk) begin
    if (!Comp_reset_n) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Addr  <= '0;
    end else begin
      Out_Valid <= s3_last && !Clear;
      if (s3_last && !Clear) Out_Data <= acc;
      if (Out_Valid) Out_Addr <= Out_Addr + Addr_Width'(1);
    end
  end
endmodule

// File: tb/tb_dot_product_datapath.sv
// Self-checking bench for dot_product_datapath against a plain-arithmetic dot-product model.
module tb_dot_product_datapath;
  import dot_pkg::*;
  localparam int DW = 8;
  localparam int NB = 2;
  localparam int AW = acc_width(DW, NB);

  typedef logic [DW-1:0] vec_t [4];

  logic          clk = 1'b0;
  logic          Comp_reset_n = 1'b0;
  logic          Clear = 1'b0;
  logic          In_Valid = 1'b0;
  logic [DW-1:0] Data_A = '0, Data_B = '0;
  logic          Out_Valid, Busy;
  logic [AW-1:0] Out_Data;
  logic [3:0]    Out_Addr;
  logic [NB-1:0] Elem_Count;

  dot_product_datapath dut (
    .clk(clk), .Comp_reset_n(Comp_reset_n), .Clear(Clear), .In_Valid(In_Valid),
    .Data_A(Data_A), .Data_B(Data_B), .Out_Valid(Out_Valid), .Out_Data(Out_Data),
    .Out_Addr(Out_Addr), .Busy(Busy), .Elem_Count(Elem_Count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0, miss = 0;
  int last_edge, first_edge;
  logic [3:0] exp_addr = '0;
  logic [AW-1:0] got_d[$], exp_d[$];
  logic [3:0]    got_a[$], exp_a[$];
  int            got_c[$], exp_c[$];
  bit            busy_hist[int];

  always @(negedge clk) begin
    busy_hist[cyc] = Busy;
    if (Out_Valid) begin
      got_d.push_back(Out_Data);
      got_a.push_back(Out_Addr);
      got_c.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [AW-1:0] ref_dot(input vec_t a, input vec_t b);
    int s = 0;
    for (int i = 0; i < 4; i++)
`ifdef DOT_SIGNED_EN
      s += int'($signed(a[i])) * int'($signed(b[i]));
`else
      s += int'(a[i]) * int'(b[i]);
`endif
    return AW'(s);
  endfunction

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit v);
    In_Valid = v; Data_A = a; Data_B = b;
    @(posedge clk); #1;
    In_Valid = 1'b0;
  endtask

  task automatic start();
    got_d.delete(); got_a.delete(); got_c.delete();
    exp_d.delete(); exp_a.delete(); exp_c.delete();
  endtask

  task automatic do_reset();
    Comp_reset_n = 1'b0;
    send('0, '0, 1'b0);
    Comp_reset_n = 1'b1;
    exp_addr = '0;
  endtask

  // gap: 0 none, 1 bubble after every element, 2 random bubbles
  task automatic push_vec(input vec_t a, input vec_t b, input int gap, input logic [AW-1:0] expv);
    for (int i = 0; i < 4; i++) begin
      send(a[i], b[i], 1'b1);
      if (i == 0) first_edge = cyc;
      if (i == 3) last_edge = cyc;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) send('0, '0, 1'b0);
    end
    exp_d.push_back(expv);
    exp_a.push_back(exp_addr);
    exp_c.push_back(last_edge + 3);
    exp_addr++;
  endtask

  task automatic test_reset();
    Comp_reset_n = 1'b0;
    In_Valid = 1'b1; Data_A = 8'd7; Data_B = 8'd9;
    @(posedge clk); #1;
    send('0, '0, 1'b0);
    vecs += 5;
    if (Out_Valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid got %b expected 0", Out_Valid); end
    if (Out_Data !== '0) begin miss++; $display("FAIL reset_out_data got %0h expected 0", Out_Data); end
    if (Out_Addr !== 4'd0) begin miss++; $display("FAIL reset_out_addr got %0d expected 0", Out_Addr); end
    if (Busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b expected 0", Busy); end
    if (Elem_Count !== 2'd0) begin miss++; $display("FAIL reset_elem_count got %0d expected 0", Elem_Count); end
    Comp_reset_n = 1'b1;
    exp_addr = '0;
  endtask

  task automatic test_back_to_back();
    vec_t a = '{8'd1, 8'd2, 8'd3, 8'd4};
    vec_t b = '{8'd5, 8'd6, 8'd7, 8'd8};
    vec_t c = '{8'd1, 8'd1, 8'd1, 8'd1};
    vec_t d = '{8'd2, 8'd2, 8'd2, 8'd2};
    start();
    push_vec(a, b, 0, 18'd70);
    push_vec(c, d, 0, 18'd8);
    repeat (6) send('0, '0, 1'b0);
    vecs++;
    if (got_d.size() !== exp_d.size()) begin
      miss++; $display("FAIL b2b_count got %0d pulses expected %0d", got_d.size(), exp_d.size());
    end else foreach (exp_d[i]) begin
      vecs++;
      if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || got_c[i] !== exp_c[i]) begin
        miss++;
        $display("FAIL b2b[%0d] data=%0d addr=%0d cyc=%0d expected data=%0d addr=%0d cyc=%0d",
                 i, got_d[i], got_a[i], got_c[i], exp_d[i], exp_a[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_bubbles();
    vec_t a = '{8'd1, 8'd2, 8'd3, 8'd4};
    vec_t b = '{8'd5, 8'd6, 8'd7, 8'd8};
    int bad = 0;
    start();
    push_vec(a, b, 1, 18'd70);
    repeat (6) send('0, '0, 1'b0);
    vecs++;
    if (got_d.size() !== 1) begin
      miss++; $display("FAIL bubble_count got %0d pulses expected 1", got_d.size());
    end else begin
      vecs++;
      if (got_d[0] !== exp_d[0] || got_a[0] !== exp_a[0] || got_c[0] !== exp_c[0]) begin
        miss++;
        $display("FAIL bubble data=%0d addr=%0d cyc=%0d expected data=%0d addr=%0d cyc=%0d",
                 got_d[0], got_a[0], got_c[0], exp_d[0], exp_a[0], exp_c[0]);
      end
    end
    for (int c = first_edge; c <= last_edge + 2; c++) if (busy_hist[c] !== 1'b1) bad++;
    vecs += 2;
    if (bad != 0) begin miss++; $display("FAIL bubble_busy_high low on %0d cycles expected 0", bad); end
    if (busy_hist[last_edge + 3] !== 1'b0) begin
      miss++; $display("FAIL bubble_busy_drain got %b expected 0", busy_hist[last_edge + 3]);
    end
  endtask

  task automatic test_extremes();
`ifdef DOT_SIGNED_EN
    vec_t a = '{8'h80, 8'h80, 8'h80, 8'h80};
    vec_t b = '{8'h80, 8'h80, 8'h80, 8'h80};
    vec_t c = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vec_t d = '{8'd1, 8'd1, 8'd1, 8'd1};
    logic [AW-1:0] e0 = 18'd65536, e1 = 18'h3FFFC;
`else
    vec_t a = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vec_t b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vec_t c = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vec_t d = '{8'd1, 8'd0, 8'd0, 8'd0};
    logic [AW-1:0] e0 = 18'd260100, e1 = 18'd255;
`endif
    start();
    push_vec(a, b, 0, e0);
    push_vec(c, d, 0, e1);
    repeat (6) send('0, '0, 1'b0);
    vecs++;
    if (got_d.size() !== exp_d.size()) begin
      miss++; $display("FAIL extreme_count got %0d pulses expected %0d", got_d.size(), exp_d.size());
    end else foreach (exp_d[i]) begin
      vecs++;
      if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || got_c[i] !== exp_c[i]) begin
        miss++;
        $display("FAIL extreme[%0d] data=%0h addr=%0d cyc=%0d expected data=%0h addr=%0d cyc=%0d",
                 i, got_d[i], got_a[i], got_c[i], exp_d[i], exp_a[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    vec_t a = '{8'd1, 8'd2, 8'd3, 8'd4};
    vec_t b = '{8'd5, 8'd6, 8'd7, 8'd8};
    start();
    send(8'd9, 8'd9, 1'b1);
    send(8'd9, 8'd9, 1'b1);
    vecs++;
    if (Elem_Count !== 2'd2) begin miss++; $display("FAIL rst_abort_count got %0d expected 2", Elem_Count); end
    do_reset();
    vecs += 2;
    if (Elem_Count !== 2'd0) begin miss++; $display("FAIL rst_abort_elem got %0d expected 0", Elem_Count); end
    if (Out_Addr !== 4'd0) begin miss++; $display("FAIL rst_abort_addr got %0d expected 0", Out_Addr); end
    push_vec(a, b, 0, 18'd70);
    repeat (6) send('0, '0, 1'b0);
    vecs++;
    if (got_d.size() !== 1) begin
      miss++; $display("FAIL rst_abort_pulses got %0d expected 1", got_d.size());
    end else begin
      vecs++;
      if (got_d[0] !== exp_d[0] || got_a[0] !== exp_a[0] || got_c[0] !== exp_c[0]) begin
        miss++;
        $display("FAIL rst_abort data=%0d addr=%0d cyc=%0d expected data=%0d addr=%0d cyc=%0d",
                 got_d[0], got_a[0], got_c[0], exp_d[0], exp_a[0], exp_c[0]);
      end
    end
  endtask

  task automatic test_clear_abort();
    vec_t a = '{8'd1, 8'd2, 8'd3, 8'd4};
    vec_t b = '{8'd5, 8'd6, 8'd7, 8'd8};
    start();
    send(8'd9, 8'd9, 1'b1);
    send(8'd9, 8'd9, 1'b1);
    Clear = 1'b1;
    send(8'd9, 8'd9, 1'b1);
    Clear = 1'b0;
    vecs += 3;
    if (Elem_Count !== 2'd0) begin miss++; $display("FAIL clr_elem got %0d expected 0", Elem_Count); end
    if (Busy !== 1'b0) begin miss++; $display("FAIL clr_busy got %b expected 0", Busy); end
    if (Out_Addr !== exp_addr) begin miss++; $display("FAIL clr_addr got %0d expected %0d", Out_Addr, exp_addr); end
    push_vec(a, b, 0, 18'd70);
    repeat (6) send('0, '0, 1'b0);
    vecs++;
    if (got_d.size() !== 1) begin
      miss++; $display("FAIL clr_pulses got %0d expected 1", got_d.size());
    end else begin
      vecs++;
      if (got_d[0] !== exp_d[0] || got_a[0] !== exp_a[0] || got_c[0] !== exp_c[0]) begin
        miss++;
        $display("FAIL clr_abort data=%0d addr=%0d cyc=%0d expected data=%0d addr=%0d cyc=%0d",
                 got_d[0], got_a[0], got_c[0], exp_d[0], exp_a[0], exp_c[0]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    vec_t a, b;
    do_reset();
    start();
    for (int v = 0; v < 17; v++) begin
      for (int i = 0; i < 4; i++) begin a[i] = DW'($urandom); b[i] = DW'($urandom); end
      push_vec(a, b, 0, ref_dot(a, b));
    end
    repeat (6) send('0, '0, 1'b0);
    vecs++;
    if (got_d.size() !== exp_d.size()) begin
      miss++; $display("FAIL wrap_count got %0d pulses expected %0d", got_d.size(), exp_d.size());
    end else foreach (exp_d[i]) begin
      vecs++;
      if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || got_c[i] !== exp_c[i]) begin
        miss++;
        $display("FAIL wrap[%0d] data=%0h addr=%0d cyc=%0d expected data=%0h addr=%0d cyc=%0d",
                 i, got_d[i], got_a[i], got_c[i], exp_d[i], exp_a[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_random();
    vec_t a, b;
    start();
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < 4; i++) begin a[i] = DW'($urandom); b[i] = DW'($urandom); end
      push_vec(a, b, 2, ref_dot(a, b));
    end
    repeat (6) send('0, '0, 1'b0);
    vecs++;
    if (got_d.size() !== exp_d.size()) begin
      miss++; $display("FAIL rand_count got %0d pulses expected %0d", got_d.size(), exp_d.size());
    end else foreach (exp_d[i]) begin
      vecs++;
      if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || got_c[i] !== exp_c[i]) begin
        miss++;
        $display("FAIL rand[%0d] data=%0h addr=%0d cyc=%0d expected data=%0h addr=%0d cyc=%0d",
                 i, got_d[i], got_a[i], got_c[i], exp_d[i], exp_a[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_extremes();
    test_reset_abort();
    test_clear_abort();
    test_addr_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/dot_product_datapath.md
# dot_product_datapath

Four-stage pipelined multiply-accumulate datapath for the dot-product engine. Consumes operand pairs read from the two input SRAMs under control of the memory controller and computes one dot product per `Nums_Data` elements. Drives write data, write address and write enable for the output SRAM. Sits directly downstream of the memory controller's read port and upstream of the output SRAM write port.

## Interface
Parameters:
- `Data_Width`, 8, operand width.
- `Addr_Width`, 4, output SRAM address width.
- `Nums_Data_in_bits`, 2, log2 of elements per vector.
- `Nums_Data`, `1 << Nums_Data_in_bits`, elements per vector.
- `Acc_Width`, `2*Data_Width + Nums_Data_in_bits`, result width; overflow-free by construction.

Ports:
- `clk` in 1: sole clock, rising edge.
- `Comp_reset_n` in 1: reset; synchronous, active-low.
- `Clear` in 1: synchronous pipeline flush.
- `In_Valid` in 1: `Data_A`/`Data_B` hold a valid pair this cycle (read data, already aligned by the controller).
- `Data_A` in `Data_Width`: operand from input SRAM 0.
- `Data_B` in `Data_Width`: operand from input SRAM 1.
- `Out_Valid` out 1: one-cycle pulse, `Out_Data` complete; doubles as output SRAM write enable.
- `Out_Data` out `Acc_Width`: dot-product result.
- `Out_Addr` out `Addr_Width`: output SRAM write address for the current `Out_Valid`.
- `Busy` out 1: any pipeline stage holds a valid element.
- `Elem_Count` out `Nums_Data_in_bits`: index of the next element to be accepted.

## Operation
- **S1 capture:** on `In_Valid`, register A, B, valid=1 and last=(`Elem_Count`==`Nums_Data`-1). Increment `Elem_Count`, wrapping to 0 after the last element.
- **S2 multiply:** register the product at `2*Data_Width` and forward valid/last.
- **S3 accumulate:** on valid, set acc to product if first element, else acc+product. The first flag sets after a last element and after reset/Clear. On invalid, acc holds.
- **S4 writeback:** when S3 completes a last element, register `Out_Data`=acc and pulse `Out_Valid` for one cycle. `Out_Addr` is the address for this write; it increments after each `Out_Valid`, wrapping from `Ram_Depth`-1 to 0.
- **Bubbles:** gaps in `In_Valid` propagate as bubbles. Results are unaffected.
- **Back-to-back vectors:** supported with zero idle cycles. The first element of vector n+1 enters S3 the cycle after the last element of vector n, and does not add to vector n's sum.
- **Clear:** zeroes all valid bits, `Elem_Count`, acc and the first flag. `Out_Addr` keeps its value. `Out_Valid` is 0 in the following cycle. If `Clear` and `In_Valid` are both asserted, `Clear` wins and the element is dropped.
- **Reset:** same as `Clear`, and additionally `Out_Addr`=0. A partial vector in flight at reset is discarded.
- **`Busy`:** OR of the S1–S3 valid bits.

## Timing
- Reset values: `Out_Valid`=0, `Out_Data`=0, `Out_Addr`=0, `Busy`=0, `Elem_Count`=0.
- Latency: last element sampled at edge k → `Out_Valid` high from edge k+3 to edge k+4.
- A full vector with no bubbles takes `Nums_Data`+3 cycles, i.e. 7 with defaults.
- Throughput: one element per cycle; one result every `Nums_Data` cycles.
- No back-pressure: the output SRAM always accepts a write.

## Configuration
- `DOT_SIGNED_EN` defined: operands, products and acc are two's-complement. `Out_Data` is sign-extended to `Acc_Width`.
- `DOT_SIGNED_EN` undefined: all arithmetic is unsigned and zero-extended.
- `Acc_Width` is overflow-free in both modes.

## Structure
- Package `dot_pkg` holds the default width constants, the `Acc_Width` derivation function and the S1–S3 stage-valid struct typedef.
- Sub-module `dot_product_mac` contains S2+S3 (multiplier, accumulator, first flag). The top level holds S1, S4, the element counter and the address counter.

## Test plan
- A={1,2,3,4}, B={5,6,7,8} streamed back-to-back after reset → single `Out_Valid` 3 edges after the last sample, `Out_Data`=70, `Out_Addr`=0.
- The previous vector immediately followed by A={1,1,1,1}, B={2,2,2,2} → second pulse exactly 4 cycles after the first, `Out_Data`=8, `Out_Addr`=1.
- A={1,2,3,4}, B={5,6,7,8} with `In_Valid` toggling 1,0,1,0 → `Out_Data`=70; `Busy` stays high until S3 drains.
- All operands 255 (unsigned) → 260100. With `DOT_SIGNED_EN`: all -128 → 65536; A={-1,-1,-1,-1}, B={1,1,1,1} → -4, i.e. 0x3FFFC at `Acc_Width`=18.
- Two elements accepted, then `Comp_reset_n`=0 for one cycle, then full vector A={1,2,3,4}, B={5,6,7,8} → no pulse for the partial vector, `Out_Data`=70 at `Out_Addr`=0. Repeating with `Clear` instead of `Comp_reset_n` keeps the prior `Out_Addr`.
- 17 consecutive vectors → `Out_Addr` runs 0..15, and the 17th result is written at 0.
